// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

  // pprot bit that marks a non-secure access
  localparam int PPROT_NONSEC_BIT = 1;

  // wide enough for WAIT_CYCLES up to 15
  localparam int WAIT_CNT_W = 4;

  // byte-offset bits within one data word
  function automatic int calc_lsb(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: lanes with strb set take new_word, the rest keep old_word.
module apb_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer in front of a byte-strobed register file.
// Programmable wait states; misaligned / out-of-range accesses return PSLVERR.
// Optional: define APB_PROT_CHECK_EN to reject non-secure (pprot[1]=1) accesses.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   pwdata,
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata
);

  localparam int LSB    = calc_lsb(DATA_W);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0]     ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_CYCLES);

  apb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];

  logic              setup;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              misaligned;
  logic              prot_err;
  logic              err;
  logic              we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;

  // penable low with psel high always starts a fresh transfer
  assign setup      = psel & ~penable;
  assign idx        = paddr[ADDR_W-1:LSB];
  assign mem_idx    = MEM_AW'(idx);
  assign in_range   = (32'(idx) < DEPTH);
  assign misaligned = |(paddr & ALIGN_MASK);

`ifdef APB_PROT_CHECK_EN
  assign prot_err = pprot[PPROT_NONSEC_BIT];
`else
  assign prot_err = 1'b0;
`endif

  // only pprot[1] can ever matter; keep the rest visibly intentional
  logic unused_pprot;
  assign unused_pprot = ^pprot;

  assign err     = misaligned | ~in_range | prot_err;
  assign rd_word = mem_q[mem_idx];
  assign we      = (state_q == READY) && pwrite && !err;

  apb_strb_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (rd_word),
    .new_word (pwdata),
    .strb     (pstrb),
    .merged   (wr_word)
  );

  // transfer sequencing: setup -> optional wait countdown -> one READY cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = (WAIT_CYCLES == 0) ? READY : WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!penable) begin
          state_d = (WAIT_CYCLES == 0) ? READY : WAIT;
          cnt_d   = WAIT_LOAD;
        end else if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY: begin
        if (setup) begin
          state_d = (WAIT_CYCLES == 0) ? READY : WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next memory image: only the addressed word changes on a clean write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[mem_idx] = wr_word;
  end

  // register file storage, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // response is driven only in READY; everything else reads as zero
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state_q == READY) begin
      pready  = 1'b1;
      pslverr = err;
      if (!pwrite && !err) prdata = rd_word;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench: two completers (0 and 3 wait states) on a shared bus, scoreboard checked.
module tb_apb_regfile_slave;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  psel_v = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [31:0] pwdata = '0;
  logic        pready_v [2];
  logic        pslverr_v [2];
  logic [31:0] prdata_v [2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mem_m [2][32];

  always #5 clk = ~clk;

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
    .pready(pready_v[0]), .pslverr(pslverr_v[0]), .prdata(prdata_v[0])
  );

  apb_regfile_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
    .pready(pready_v[1]), .pslverr(pslverr_v[1]), .prdata(prdata_v[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) mem_m[d][i] = '0;
  endtask

  // reference behaviour of one transfer; updates the model memory
  task automatic model_push(input int d, input bit wr, input logic [7:0] addr,
                            input logic [3:0] strb, input logic [31:0] data,
                            input logic [2:0] prot);
    exp_t e;
    int   i;
    i     = int'(addr[6:2]);
    e.err = (addr[1:0] != 2'b00) || (addr >= 8'h80);
`ifdef APB_PROT_CHECK_EN
    if (prot[1]) e.err = 1'b1;
`endif
    e.rd  = (!wr && !e.err) ? mem_m[d][i] : 32'h0;
    e.lat = (d == 0) ? 0 : 3;
    if (wr && !e.err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[d][i][8*b +: 8] = data[8*b +: 8];
    sb.push_back(e);
  endtask

  task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                      input logic [3:0] strb, input logic [31:0] data,
                      input logic [2:0] prot);
    exp_t e;
    int   lat;
    @(negedge clk);
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pstrb     = strb;
    pwdata    = data;
    pprot     = prot;
    model_push(d, wr, addr, strb, data, prot);
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    #1;
    while (!pready_v[d] && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk($sformatf("lat d%0d a%0h", d, addr), 64'(lat), 64'(e.lat));
    chk($sformatf("err d%0d a%0h", d, addr), 64'(pslverr_v[d]), 64'(e.err));
    chk($sformatf("rd d%0d a%0h", d, addr), 64'(prdata_v[d]), 64'(e.rd));
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel_v  = '0;
    penable = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst pready d%0d", d), 64'(pready_v[d]), 64'(0));
      chk($sformatf("rst pslverr d%0d", d), 64'(pslverr_v[d]), 64'(0));
      chk($sformatf("rst prdata d%0d", d), 64'(prdata_v[d]), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;

    // basic write / read, full and partial strobes
    xfer(0, 1, 8'h04, 4'hF, 32'hDEADBEEF, 3'b000);
    xfer(0, 0, 8'h04, 4'h0, 32'h0, 3'b000);
    xfer(0, 1, 8'h08, 4'hF, 32'h11223344, 3'b000);
    xfer(0, 1, 8'h08, 4'b0101, 32'hAABBCCDD, 3'b000);
    xfer(0, 0, 8'h08, 4'h0, 32'h0, 3'b000);
    chk("merge const", 64'(mem_m[0][2]), 64'h11BB33DD);
    xfer(0, 1, 8'h08, 4'h0, 32'hFFFFFFFF, 3'b000);
    xfer(0, 0, 8'h08, 4'h0, 32'h0, 3'b000);

    // error responses
    xfer(0, 0, 8'h80, 4'h0, 32'h0, 3'b000);
    xfer(0, 1, 8'h06, 4'hF, 32'h12345678, 3'b000);
    xfer(0, 0, 8'h04, 4'h0, 32'h0, 3'b000);
    xfer(0, 1, 8'hFC, 4'hF, 32'h12345678, 3'b000);
    xfer(0, 0, 8'h7C, 4'h0, 32'h0, 3'b000);

    // protection
    xfer(0, 1, 8'h10, 4'hF, 32'hCAFEF00D, 3'b010);
    xfer(0, 0, 8'h10, 4'h0, 32'h0, 3'b000);
    xfer(0, 1, 8'h10, 4'hF, 32'hCAFEF00D, 3'b000);
    xfer(0, 0, 8'h10, 4'h0, 32'h0, 3'b000);

    // wait states: exactly three low access cycles, then a single ready cycle
    xfer(1, 1, 8'h04, 4'hF, 32'h0BADCAFE, 3'b000);
    bus_idle();
    chk("w3 one-cycle ready wr", 64'(pready_v[1]), 64'(0));
    xfer(1, 0, 8'h04, 4'h0, 32'h0, 3'b000);
    bus_idle();
    chk("w3 one-cycle ready rd", 64'(pready_v[1]), 64'(0));
    xfer(1, 0, 8'h81, 4'h0, 32'h0, 3'b000);

    // abort during WAIT leaves memory alone
    @(negedge clk);
    psel_v = 2'b10; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h20; pstrb = 4'hF; pwdata = 32'hFFFFFFFF; pprot = 3'b000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_v = '0; penable = 1'b0;
    @(negedge clk);
    #1;
    chk("abort state", 64'(u_w3.state_q), 64'(IDLE));
    xfer(1, 0, 8'h20, 4'h0, 32'h0, 3'b000);

    // randomized traffic on both completers
    for (int n = 0; n < 40; n++) begin
      int          d, r;
      logic [7:0]  a;
      d = n % 2;
      r = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 31) * 4);
      if (r == 0) a = 8'h80 | a;
      if (r == 1) a = a | 8'($urandom_range(1, 3));
      xfer(d, bit'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
           $urandom, 3'($urandom_range(0, 7)));
    end
    bus_idle();

    // reset mid-transfer
    xfer(1, 1, 8'h0C, 4'hF, 32'h77777777, 3'b000);
    @(negedge clk);
    psel_v = 2'b10; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h0C; pstrb = 4'hF; pwdata = 32'h5A5A5A5A; pprot = 3'b000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst mid pready", 64'(pready_v[1]), 64'(0));
    chk("rst mid state", 64'(u_w3.state_q), 64'(IDLE));
    model_clear();
    @(negedge clk);
    psel_v = '0; penable = 1'b0;
    reset = 1'b0;
    xfer(1, 0, 8'h0C, 4'h0, 32'h0, 3'b000);
    xfer(0, 0, 8'h04, 4'h0, 32'h0, 3'b000);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB4 completer with a byte-strobed register file, programmable wait states and error response. It supersedes the fixed 32×32 APB slave. Width, depth and access latency are compile-time parameters. Out-of-range, misaligned and (optionally) non-secure accesses complete with PSLVERR instead of being silently dropped. It sits behind the APB master/bridge as a generic peripheral register bank.

## Interface
- DATA_W, 32, data bus width; must be 8, 16, 32 or 64
- ADDR_W, 8, byte-address width
- DEPTH, 32, number of DATA_W-bit registers; must satisfy DEPTH*(DATA_W/8) ≤ 2^ADDR_W
- WAIT_CYCLES, 0, extra access-phase cycles before PREADY; range 0..15
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- psel  input  1  slave select
- penable  input  1  access phase
- pwrite  input  1  1 = write, 0 = read
- paddr  input  ADDR_W  byte address
- pstrb  input  DATA_W/8  write byte-lane enables
- pprot  input  3  protection type; only bit 1 (non-secure) is used
- pwdata  input  DATA_W  write data
- pready  output  1  transfer completes this cycle
- pslverr  output  1  error response; valid only while pready=1
- prdata  output  DATA_W  read data; valid only while pready=1 and pwrite=0

## Operation
- Word index = paddr[ADDR_W-1:LSB], where LSB = log2(DATA_W/8).
- Error conditions are evaluated combinationally in the completing cycle:
  - misaligned: paddr[LSB-1:0] ≠ 0 (never fires for DATA_W=8)
  - out of range: word index ≥ DEPTH
  - protection violation, only when the macro below is defined
- FSM states are held in a registered enum (IDLE, WAIT, READY):
  - IDLE: no transfer. Setup cycle (psel=1, penable=0) → WAIT with cnt=WAIT_CYCLES, or → READY if WAIT_CYCLES=0.
  - WAIT: pready=0. psel=0 → IDLE (abort, no side effect). cnt==1 → READY. Otherwise cnt decrements.
  - READY: pready=1. Setup cycle → WAIT or READY (back-to-back transfer). Otherwise → IDLE.
  - penable=0 while in WAIT or READY with psel=1 is treated as a new setup cycle; the counter reloads.
- Write, in READY with no error: at the clock edge, each lane i with pstrb[i]=1 takes pwdata[8i+7:8i]; other lanes hold. pstrb=0 is a legal no-op with pslverr=0.
- Read, in READY with no error: prdata = mem[index], combinational from the array.
- Any error: no memory change, prdata=0, pslverr=1.
- Outside READY: pready=0, pslverr=0, prdata=0.
- Reset: all registers cleared to 0, state=IDLE, cnt=0, all outputs 0. Asserting reset mid-transfer aborts the transfer; the memory keeps its reset value.

## Timing
- Latency from the setup cycle to pready is 1+WAIT_CYCLES cycles. WAIT_CYCLES=0 gives a zero-wait APB transfer.
- Write data is visible to a read whose setup cycle is the cycle after the write's READY cycle.
- Back-to-back transfers: the READY cycle of one transfer may be followed directly by the setup cycle of the next, with no IDLE in between.
- pready, pslverr and prdata are combinational from state and bus inputs. There is no input-to-output path outside READY.

## Configuration
- APB_PROT_CHECK_EN defined: a transfer with pprot[1]=1 (non-secure) is a protection violation. It completes with pslverr=1, performs no write and returns prdata=0.
- APB_PROT_CHECK_EN undefined: pprot is ignored and all accesses are permitted.

## Structure
- Package apb_pkg holds:
  - the apb_state_e enum (IDLE, WAIT, READY)
  - the PPROT_NONSEC_BIT=1 constant
  - the WAIT_CNT_W=4 constant
  - a function that computes LSB from DATA_W
- Sub-module apb_strb_merge (parameter DATA_W) performs the byte-lane merge of pwdata into the old word under pstrb. It is purely combinational and instantiated once.

## Test plan
- Reset, then DATA_W=32, WAIT_CYCLES=0: write 0xDEADBEEF to 0x04 with pstrb=4'hF, then read 0x04 → pready in the first access cycle, prdata=0xDEADBEEF, pslverr=0.
- Write 0x11223344 to 0x08 with pstrb=4'hF, then 0xAABBCCDD with pstrb=4'b0101 → readback 0x11BB33DD.
- WAIT_CYCLES=3: any read → pready low for exactly 3 access cycles, high on the 4th, and for one cycle only.
- Out-of-range read at byte address 0x80 (DEPTH=32), and a write to 0x06 → both pslverr=1 with pready; the write leaves memory unchanged; the read returns prdata=0.
- With APB_PROT_CHECK_EN: write with pprot=3'b010 → pslverr=1 and no update; the same write with pprot=3'b000 → pslverr=0 and the update lands.
- Assert reset during WAIT of a write to 0x0C → pready=0 and state IDLE immediately; a subsequent read of 0x0C returns 0.
